alu_dispatch: RTL and testbench

- Issue-side partner of the ALU: buffers incoming 32-bit MIPS instructions and classifies each one.
- ALU-class instructions are driven to the ALU as an `instruction` bus plus a single-cycle `alu` strobe. The ALU samples on the strobe's rising edge, so `alu` must return low between issues.
- Non-ALU instructions (loads, stores, branches, jumps) go out in order on a side port.
- Sits between the fetch stage and the ALU in the mini-MIPS datapath.

---
 rtl/alu_dispatch_if.sv | 28 ++
 rtl/alu_dispatch.sv | 149 ++++++++++++++
 tb/tb_alu_dispatch.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_dispatch_if.sv
// Signal bundle between the fetch stage, alu_dispatch and the ALU.
// master = upstream/test side, slave = the dispatch block.
interface alu_dispatch_if #(
  parameter int DEPTH   = 4,
  parameter int STALL_W = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic               alu;
  logic [31:0]        instruction;
  logic               other_valid;
  logic [31:0]        other_instr;
  logic [CNT_W-1:0]   fifo_count;
  logic [STALL_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_instr,
    input  in_ready, alu, instruction, other_valid, other_instr, fifo_count, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, alu, instruction, other_valid, other_instr, fifo_count, stall_cnt
  );
endinterface

// File: rtl/alu_dispatch.sv
// Instruction FIFO + classifier: ALU-class words strobe out to the ALU, others go to a side port.
// Optional upstream stall counter enabled by defining ALU_DISPATCH_STALL_CNT_EN.
module alu_dispatch #(
  parameter int DEPTH     = 4,
  parameter int ISSUE_GAP = 1,
  parameter int STALL_W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_dispatch_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(ISSUE_GAP + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic is_alu_op(input logic [5:0] op);
    return (op == 6'h00) || ((op >= 6'h08) && (op <= 6'h0F));
  endfunction

  // FIFO state
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_q;

  // FSM and registered outputs
  state_t           state_q;
  logic [GAP_W-1:0] gap_q;
  logic             alu_q;
  logic [31:0]      instr_q;
  logic             other_valid_q;
  logic [31:0]      other_instr_q;

  logic        push, pop, head_avail;
  logic [31:0] head;

  assign bus.in_ready = (count_q != CNT_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign head         = mem_q[rd_ptr_q];

  // A word written on the previous edge is not yet readable, so a lone fresh entry waits a cycle.
  assign head_avail = (count_q > CNT_W'(1)) || ((count_q == CNT_W'(1)) && !push_q);
  assign pop        = (state_q == IDLE) && head_avail;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_instr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      push_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      push_q  <= push;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gap_q         <= '0;
      alu_q         <= 1'b0;
      instr_q       <= '0;
      other_valid_q <= 1'b0;
      other_instr_q <= '0;
    end else begin
      alu_q         <= 1'b0;
      other_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            if (is_alu_op(head[31:26])) begin
              instr_q <= head;
              alu_q   <= 1'b1;
              state_q <= ISSUE;
            end else begin
              other_instr_q <= head;
              other_valid_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          gap_q   <= GAP_W'(ISSUE_GAP);
          state_q <= GAP;
        end
        GAP: begin
          // The head stays queued here, which keeps both output classes in program order.
          gap_q <= gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu         = alu_q;
  assign bus.instruction = instr_q;
  assign bus.other_valid = other_valid_q;
  assign bus.other_instr = other_instr_q;
  assign bus.fifo_count  = count_q;

`ifdef ALU_DISPATCH_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (bus.in_valid && !bus.in_ready && (stall_q != {STALL_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed sequences, a classification table and
// randomized traffic compared against a timestamped queue model.
module tb_alu_dispatch;
  localparam int DEPTH   = 4;
  localparam int STALL_W = 16;
  localparam int GAP0    = 1;
  localparam int GAP1    = 4;

  logic clk;
  logic rst_n;

  alu_dispatch_if #(.DEPTH(DEPTH), .STALL_W(STALL_W)) if0 ();
  alu_dispatch_if #(.DEPTH(DEPTH), .STALL_W(STALL_W)) if1 ();

  alu_dispatch #(.DEPTH(DEPTH), .ISSUE_GAP(GAP0), .STALL_W(STALL_W)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if0)
  );

  alu_dispatch #(.DEPTH(DEPTH), .ISSUE_GAP(GAP1), .STALL_W(STALL_W)) u_gap4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit ref_is_alu(input logic [31:0] w);
    case (w[31:26])
      6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: a queue of words stamped with their accept cycle. A word may leave
  // two cycles after acceptance, and only once the previous issue's spacing has elapsed.
  typedef struct {
    logic [31:0] w;
    int          t;
  } entry_t;

  entry_t      mq[$];
  int          cyc;
  int          next_ok;
  logic        m_alu, m_ov;
  logic [31:0] m_instruction, m_other;
  int          m_stall;

  int          alu_log[$];
  logic [31:0] alu_val[$];
  int          oth_log[$];
  logic [31:0] oth_val[$];

  task automatic model_reset();
    mq.delete();
    next_ok       = 0;
    m_alu         = 1'b0;
    m_ov          = 1'b0;
    m_instruction = '0;
    m_other       = '0;
    m_stall       = 0;
  endtask

  task automatic clear_logs();
    alu_log.delete();
    alu_val.delete();
    oth_log.delete();
    oth_val.delete();
  endtask

  // One clock on the default instance; entered and left at a falling edge.
  task automatic step(input logic v, input logic [31:0] w);
    bit     ready;
    entry_t e;
    if0.in_valid = v;
    if0.in_instr = w;
    ready = (mq.size() < DEPTH);
    @(posedge clk);
    cyc++;
    m_alu = 1'b0;
    m_ov  = 1'b0;
    if ((mq.size() > 0) && (mq[0].t <= cyc - 2) && (cyc >= next_ok)) begin
      e = mq.pop_front();
      if (ref_is_alu(e.w)) begin
        m_alu         = 1'b1;
        m_instruction = e.w;
        next_ok       = cyc + GAP0 + 2;
      end else begin
        m_ov    = 1'b1;
        m_other = e.w;
        next_ok = cyc + 1;
      end
    end
    if (v && ready) mq.push_back('{w, cyc});
    if (v && !ready && (m_stall < (1 << STALL_W) - 1)) m_stall++;
    @(negedge clk);
    check("alu", 32'(if0.alu), 32'(m_alu));
    check("instruction", if0.instruction, m_instruction);
    check("other_valid", 32'(if0.other_valid), 32'(m_ov));
    check("other_instr", if0.other_instr, m_other);
    check("fifo_count", 32'(if0.fifo_count), 32'(mq.size()));
    check("in_ready", 32'(if0.in_ready), 32'(mq.size() < DEPTH));
`ifdef ALU_DISPATCH_STALL_CNT_EN
    check("stall_cnt", 32'(if0.stall_cnt), 32'(m_stall));
`else
    check("stall_cnt", 32'(if0.stall_cnt), 32'd0);
`endif
    if (if0.alu) begin
      alu_log.push_back(cyc);
      alu_val.push_back(if0.instruction);
    end
    if (if0.other_valid) begin
      oth_log.push_back(cyc);
      oth_val.push_back(if0.other_instr);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    bit          exp_alu;
  } cls_vec_t;

  cls_vec_t cls_tab[15];

  function automatic logic [31:0] rand_word();
    logic [5:0] ops [9];
    logic [5:0] op;
    ops = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    if ($urandom_range(0, 1) == 1) op = ops[$urandom_range(0, 8)];
    else op = 6'($urandom_range(0, 63));
    return {op, 26'($urandom)};
  endfunction

  initial begin
    int          base;
    logic [31:0] words [8];
    int          idx, cycles, stall_seen, max_cnt, full_err;
    bit          rdy;
    int          s_cyc[$];
    logic [31:0] s_val[$];

    cls_tab = '{
      '{32'h00221820, 1'b1}, '{32'h20220005, 1'b1}, '{32'h24220005, 1'b1},
      '{32'h28220005, 1'b1}, '{32'h2C220005, 1'b1}, '{32'h30220005, 1'b1},
      '{32'h34220005, 1'b1}, '{32'h38220005, 1'b1}, '{32'h3C01ABCD, 1'b1},
      '{32'h8C410004, 1'b0}, '{32'hAC410004, 1'b0}, '{32'h10220003, 1'b0},
      '{32'h08000010, 1'b0}, '{32'h1C200002, 1'b0}, '{32'h40806000, 1'b0}
    };

    // Test 1: reset held for three cycles with in_valid asserted
    rst_n        = 1'b0;
    if0.in_valid = 1'b1;
    if0.in_instr = 32'h00221820;
    if1.in_valid = 1'b0;
    if1.in_instr = '0;
    cyc = 0;
    model_reset();
    clear_logs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_alu", 32'(if0.alu), 32'd0);
    check("rst_instruction", if0.instruction, 32'd0);
    check("rst_in_ready", 32'(if0.in_ready), 32'd1);
    check("rst_fifo_count", 32'(if0.fifo_count), 32'd0);
    check("rst_other_valid", 32'(if0.other_valid), 32'd0);
    check("rst_other_instr", if0.other_instr, 32'd0);
    check("rst_stall_cnt", 32'(if0.stall_cnt), 32'd0);
    rst_n = 1'b1;

    // Test 2: single R-type word
    step(1'b1, 32'h00221820);
    check("t2_count_after_accept", 32'(if0.fifo_count), 32'd1);
    repeat (9) step(1'b0, '0);
    check("t2_strobe_count", 32'(alu_log.size()), 32'd1);
    if (alu_log.size() == 1) check("t2_strobe_cycle", 32'(alu_log[0]), 32'd3);
    check("t2_instr_hold", if0.instruction, 32'h00221820);
    check("t2_count_empty", 32'(if0.fifo_count), 32'd0);

    // Test 3: three ALU words back to back
    clear_logs();
    base = cyc;
    step(1'b1, 32'h00221820);
    step(1'b1, 32'h20220005);
    step(1'b1, 32'h3C01ABCD);
    repeat (10) step(1'b0, '0);
    check("t3_strobe_count", 32'(alu_log.size()), 32'd3);
    if (alu_log.size() == 3) begin
      check("t3_first_cycle", 32'(alu_log[0] - base), 32'd3);
      check("t3_spacing_a", 32'(alu_log[1] - alu_log[0]), 32'd3);
      check("t3_spacing_b", 32'(alu_log[2] - alu_log[1]), 32'd3);
      check("t3_val0", alu_val[0], 32'h00221820);
      check("t3_val1", alu_val[1], 32'h20220005);
      check("t3_val2", alu_val[2], 32'h3C01ABCD);
    end

    // Test 4: load followed by addi
    clear_logs();
    base = cyc;
    step(1'b1, 32'h8C410004);
    step(1'b1, 32'h20220005);
    repeat (8) step(1'b0, '0);
    check("t4_other_count", 32'(oth_log.size()), 32'd1);
    check("t4_alu_count", 32'(alu_log.size()), 32'd1);
    if (oth_log.size() == 1 && alu_log.size() == 1) begin
      check("t4_other_cycle", 32'(oth_log[0] - base), 32'd3);
      check("t4_other_val", oth_val[0], 32'h8C410004);
      check("t4_alu_cycle", 32'(alu_log[0] - base), 32'd4);
      check("t4_alu_val", alu_val[0], 32'h20220005);
    end

    // Classification table
    for (int i = 0; i < 15; i++) begin
      clear_logs();
      step(1'b1, cls_tab[i].instr);
      repeat (5) step(1'b0, '0);
      check($sformatf("cls%0d_alu", i), 32'(alu_log.size()), 32'(cls_tab[i].exp_alu));
      check($sformatf("cls%0d_other", i), 32'(oth_log.size()), 32'(!cls_tab[i].exp_alu));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 65, rand_word());
    end
    repeat (12) step(1'b0, '0);
    check("rand_drained", 32'(if0.fifo_count), 32'd0);

    // Test 5: ISSUE_GAP=4 instance, in_valid held with eight ALU words
    for (int i = 0; i < 8; i++) words[i] = {6'h08, 5'd1, 5'd2, 16'(i + 16'h100)};
    idx        = 0;
    cycles     = 0;
    stall_seen = 0;
    max_cnt    = 0;
    full_err   = 0;
    if1.in_valid = 1'b1;
    if1.in_instr = words[0];
    while ((s_cyc.size() < 8) && (cycles < 400)) begin
      rdy = if1.in_ready;
      if (idx < 8 && !rdy) stall_seen++;
      @(posedge clk);
      if (idx < 8 && rdy) idx++;
      @(negedge clk);
      cycles++;
      if (if1.alu) begin
        s_cyc.push_back(cycles);
        s_val.push_back(if1.instruction);
      end
      if (int'(if1.fifo_count) > max_cnt) max_cnt = int'(if1.fifo_count);
      if ((int'(if1.fifo_count) == DEPTH) == if1.in_ready) full_err++;
      if (idx < 8) if1.in_instr = words[idx];
      else if1.in_valid = 1'b0;
    end
    if1.in_valid = 1'b0;
    check("t5_strobe_count", 32'(s_cyc.size()), 32'd8);
    check("t5_max_count", 32'(max_cnt), 32'd4);
    check("t5_ready_vs_full", 32'(full_err), 32'd0);
    check("t5_stall_cycles", 32'(stall_seen), 32'd14);
`ifdef ALU_DISPATCH_STALL_CNT_EN
    check("t5_stall_cnt", 32'(if1.stall_cnt), 32'd14);
`else
    check("t5_stall_cnt", 32'(if1.stall_cnt), 32'd0);
`endif
    if (s_cyc.size() == 8) begin
      check("t5_first_cycle", 32'(s_cyc[0]), 32'd3);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t5_val%0d", i), s_val[i], words[i]);
        if (i > 0) check($sformatf("t5_spacing%0d", i), 32'(s_cyc[i] - s_cyc[i-1]), 32'd6);
      end
    end

    // Test 6: reset asserted while alu is high with two words queued
    clear_logs();
    step(1'b1, 32'h00221820);
    step(1'b1, 32'h20220005);
    step(1'b1, 32'h3C01ABCD);
    if0.in_valid = 1'b0;
    check("t6_alu_before", 32'(if0.alu), 32'd1);
    check("t6_count_before", 32'(if0.fifo_count), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t6_alu_in_reset", 32'(if0.alu), 32'd0);
    check("t6_count_in_reset", 32'(if0.fifo_count), 32'd0);
    check("t6_instr_in_reset", if0.instruction, 32'd0);
    check("t6_ready_in_reset", 32'(if0.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_logs();
    repeat (8) step(1'b0, '0);
    check("t6_no_strobe", 32'(alu_log.size() + oth_log.size()), 32'd0);
    step(1'b1, 32'h34220077);
    repeat (4) step(1'b0, '0);
    check("t6_new_strobe", 32'(alu_log.size()), 32'd1);
    if (alu_log.size() == 1) check("t6_new_val", alu_val[0], 32'h34220077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
